// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: signal bundle between the CPU/pad side and the PS/2 host transmitter.
//
// Signals
//   start    CPU -> tx   one-cycle send request
//   din      CPU -> tx   command byte, captured on an accepted start
//   ack      CPU -> tx   interrupt acknowledge, clears done/err
//   ps2c_in  pad -> tx   raw PS/2 clock line level
//   ps2d_in  pad -> tx   raw PS/2 data line level
//   ps2c_oe  tx -> pad   1 = pull clock line low
//   ps2d_oe  tx -> pad   1 = pull data line low
//   busy     tx -> CPU   transfer in progress
//   done     tx -> CPU   level interrupt request
//   err      tx -> CPU   valid with done; 1 = NACK or timeout
//
// The master modport is the combined CPU and pad side; slave is the transmitter.
interface ps2_host_tx_if;
    logic       start;
    logic [7:0] din;
    logic       ack;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, din, ack, ps2c_in, ps2d_in,
        input  ps2c_oe, ps2d_oe, busy, done, err
    );

    modport slave (
        input  start, din, ack, ps2c_in, ps2d_in,
        output ps2c_oe, ps2d_oe, busy, done, err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter for one command byte.
//
// The host inhibits the bus, issues request-to-send, then presents start, 8 data bits
// (LSB first), odd parity and stop, advancing one bit per device falling clock edge.
// On the 11th falling edge the device's ACK/NACK is sampled; once both lines are idle
// the level interrupt done is raised with err describing the outcome. A watchdog
// aborts the transfer when the device stops clocking.
//
// Ports
//   clk    system clock
//   reset  synchronous, active-high
//   bus    ps2_host_tx_if.slave (start/din/ack, raw lines, open-drain enables, status)
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave bus
);

    localparam int unsigned FltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

    // Index into the line arrays below.
    localparam int unsigned LineC = 0;
    localparam int unsigned LineD = 1;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StSend,
        StAck,
        StWaitIdle,
        StFinish
    } state_e;

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizer then a run-length glitch filter
    // ------------------------------------------------------------------
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    filt_q, filt_d;
    logic [FltW-1:0] flt_cnt_q [2];
    logic [FltW-1:0] flt_cnt_d [2];
    logic          fall_q;

    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = '{default: '0};
        for (int i = 0; i < 2; i++) begin
            // Count consecutive samples that disagree with the filtered level; any
            // agreeing sample restarts the run.
            if (sync2_q[i] != filt_q[i]) begin
                if (flt_cnt_q[i] == FltW'(FILTER_LEN - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    flt_cnt_d[i] = flt_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            filt_q    <= 2'b11;
            flt_cnt_q <= '{default: '0};
            fall_q    <= 1'b0;
        end else begin
            sync1_q   <= {bus.ps2d_in, bus.ps2c_in};
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            flt_cnt_q <= flt_cnt_d;
            fall_q    <= filt_q[LineC] & ~filt_d[LineC];
        end
    end

    // ------------------------------------------------------------------
    // Transfer state machine
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [8:0]      sr_q, sr_d;          // {stop, parity, data}; bit 0 is on the wire
    logic [3:0]      idx_q, idx_d;        // 0 = start bit, 10 = stop bit
    logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic            err_pending_q, err_pending_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            c_oe, d_oe, busy;
    logic            watched;             // states guarded by the device-clock watchdog

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        idx_d         = idx_q;
        inh_cnt_d     = inh_cnt_q;
        to_cnt_d      = to_cnt_q;
        err_pending_d = err_pending_q;
        done_d        = done_q;
        err_d         = err_q;
        c_oe          = 1'b0;
        d_oe          = 1'b0;
        busy          = 1'b1;
        watched       = 1'b0;

        if (bus.ack) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (bus.start) begin
                    state_d       = StInhibit;
                    sr_d          = {1'b1, ~^bus.din, bus.din};
                    idx_d         = '0;
                    inh_cnt_d     = '0;
                    err_pending_d = 1'b0;
                    done_d        = 1'b0;
                    err_d         = 1'b0;
                end
            end

            StInhibit: begin
                c_oe = 1'b1;
                if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
                    state_d = StRts;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end

            StRts: begin
                c_oe     = 1'b1;
                d_oe     = 1'b1;
                state_d  = StSend;
                to_cnt_d = '0;
            end

            StSend: begin
                watched = 1'b1;
                d_oe    = (idx_q == 4'd0) ? 1'b1 : ~sr_q[0];
                if (fall_q) begin
                    if (idx_q == 4'd10) begin
                        // 11th fall: device drives its ACK (low) or leaves data high.
                        err_pending_d = filt_q[LineD];
                        state_d       = StAck;
                    end else begin
                        // The first fall only retires the start bit, so d0 is already
                        // at sr_q[0]; later falls shift the next bit in.
                        if (idx_q != 4'd0) begin
                            sr_d = {1'b1, sr_q[8:1]};
                        end
                        idx_d = idx_q + 4'd1;
                    end
                end
            end

            StAck: begin
                watched = 1'b1;
                state_d = StWaitIdle;
            end

            StWaitIdle: begin
                watched = 1'b1;
                if (&filt_q) begin
                    state_d = StFinish;
                end
            end

            StFinish: begin
                busy    = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Watchdog between device falling edges.
        if (watched) begin
            if (fall_q) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
                if (state_d != StFinish) begin
                    state_d       = StFinish;
                    err_pending_d = 1'b1;
                end
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        // Flags are raised on the edge that enters FINISH so done and the fall of
        // busy coincide; setting overrides a same-cycle ack.
        if (state_d == StFinish && state_q != StFinish) begin
            done_d = 1'b1;
            err_d  = err_pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            sr_q          <= '0;
            idx_q         <= '0;
            inh_cnt_q     <= '0;
            to_cnt_q      <= '0;
            err_pending_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            idx_q         <= idx_d;
            inh_cnt_q     <= inh_cnt_d;
            to_cnt_q      <= to_cnt_d;
            err_pending_q <= err_pending_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Outputs are decoded from registers only, so the pads never see input-driven glitches.
    assign bus.ps2c_oe = c_oe;
    assign bus.ps2d_oe = d_oe;
    assign bus.busy    = busy;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized scoreboard bench for ps2_host_tx with a PS/2 device model.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 20;
    localparam int unsigned FLT  = 4;
    localparam int unsigned TO   = 2000;
    localparam int unsigned HALF = 100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .FILTER_LEN    (FLT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Open-drain wired-AND lines: low if either side pulls.
    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;
    assign bus.ps2c_in = ~(bus.ps2c_oe | dev_c_low);
    assign bus.ps2d_in = ~(bus.ps2d_oe | dev_d_low);

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          has_frame;
        logic [10:0] frame;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] obs_q[$];
    int          exp_inh_q[$];

    bit dev_en     = 1'b1;
    bit dev_nack   = 1'b0;
    bit dev_glitch = 1'b0;
    bit dev_active = 1'b0;
    int dev_falls  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Wire image of a byte: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            f[k+1] = b[k];
            ones += int'(b[k]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] b, input bit exp_err, input bit exp_frame);
        exp_t e;
        e.has_frame = exp_frame;
        e.frame     = frame_of(b);
        e.err       = exp_err;
        @(negedge clk);
        bus.start = 1'b1;
        bus.din   = b;
        exp_q.push_back(e);
        exp_inh_q.push_back(INH + 1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.din   = 8'($urandom);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.done, 1);
    endtask

    task automatic wait_falls(input int target);
        int n;
        n = 0;
        while (dev_falls < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("device_fall_reached", (dev_falls >= target), 1);
    endtask

    task automatic do_ack();
        @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        check("done_after_ack", bus.done, 0);
        check("err_after_ack", bus.err, 0);
    endtask

    // Device model: answers request-to-send with 11 clocks, samples on rising edges.
    initial begin : device
        forever begin
            @(negedge clk);
            if (dev_en && !dev_active && bus.ps2c_in === 1'b1 && bus.ps2d_in === 1'b0) begin
                logic [10:0] got;
                dev_active = 1'b1;
                got        = '1;
                got[0]     = bus.ps2d_in;
                repeat (50) @(negedge clk);
                for (int i = 1; i <= 11; i++) begin
                    dev_c_low = 1'b1;
                    dev_falls = i;
                    repeat (HALF) @(negedge clk);
                    dev_c_low = 1'b0;
                    if (i <= 10) got[i] = bus.ps2d_in;
                    if (i == 10) obs_q.push_back(got);
                    if (dev_glitch && i == 3) begin
                        repeat (40) @(negedge clk);
                        dev_c_low = 1'b1;
                        repeat (3) @(negedge clk);
                        dev_c_low = 1'b0;
                        repeat (HALF - 43) @(negedge clk);
                    end else if (i == 10) begin
                        repeat (HALF / 2) @(negedge clk);
                        if (!dev_nack) dev_d_low = 1'b1;
                        repeat (HALF / 2) @(negedge clk);
                    end else begin
                        repeat (HALF) @(negedge clk);
                    end
                end
                dev_d_low  = 1'b0;
                dev_falls  = 0;
                dev_active = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every rising done retires one expected transfer.
    initial begin : monitor
        bit   done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1 && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("done_without_request", bus.done, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("err_flag", bus.err, e.err);
                    check("busy_at_done", bus.busy, 0);
                    check("lines_released_at_done", {bus.ps2c_oe, bus.ps2d_oe}, 0);
                    if (e.has_frame) begin
                        if (obs_q.size() == 0) check("frame_missing", obs_q.size(), 1);
                        else check("frame", obs_q.pop_front(), e.frame);
                    end
                end
            end
            done_prev = (bus.done === 1'b1);
        end
    end

    // Inhibit-length monitor: length of each run of ps2c_oe=1.
    initial begin : inhibit_mon
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (bus.ps2c_oe === 1'b1) begin
                run++;
            end else if (run > 0) begin
                if (exp_inh_q.size() == 0) check("inhibit_unrequested", run, 0);
                else check("inhibit_len", run, exp_inh_q.pop_front());
                run = 0;
            end
        end
    end

    initial begin : watchdog
        #950000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [7:0] b;
        int n;
        bit ok;
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        bus.din   = 8'h00;
        reset     = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_err", bus.err, 0);
        check("reset_ps2c_oe", bus.ps2c_oe, 0);
        check("reset_ps2d_oe", bus.ps2d_oe, 0);
        repeat (10) @(negedge clk);

        // 0xED with ACK; done holds until ack.
        send(8'hED, 1'b0, 1'b1);
        check("busy_after_start", bus.busy, 1);
        check("inhibit_after_start", bus.ps2c_oe, 1);
        wait_done("done_0xED");
        repeat (10) @(negedge clk);
        check("done_held", bus.done, 1);
        check("err_held", bus.err, 0);
        do_ack();

        // 0x01 with NACK.
        dev_nack = 1'b1;
        send(8'h01, 1'b1, 1'b1);
        wait_done("done_nack");
        do_ack();
        dev_nack = 1'b0;

        // No device clocking: watchdog abort.
        dev_en = 1'b0;
        send(8'($urandom), 1'b1, 1'b0);
        n = 0;
        while (bus.ps2d_oe !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        ok = (n >= 2000 && n <= 2002);
        check("timeout_latency_ok", ok, 1);
        do_ack();
        dev_en = 1'b1;
        repeat (20) @(negedge clk);

        // Short clock glitch during SEND must not advance a bit.
        dev_glitch = 1'b1;
        send(8'($urandom), 1'b0, 1'b1);
        wait_done("done_glitch");
        do_ack();
        dev_glitch = 1'b0;

        // start while busy is ignored; start while done restarts.
        b = 8'($urandom);
        if (b == 8'h55) b = 8'hA3;
        send(b, 1'b0, 1'b1);
        wait_falls(3);
        @(negedge clk);
        bus.start = 1'b1;
        bus.din   = 8'h55;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("done_busy_start");
        repeat (5) @(negedge clk);
        send(8'($urandom), 1'b0, 1'b1);
        check("done_cleared_by_start", bus.done, 0);
        check("busy_after_restart", bus.busy, 1);
        wait_done("done_restart");
        do_ack();

        // Reset at the 5th device fall.
        send(8'($urandom), 1'b0, 1'b1);
        wait_falls(5);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_ps2c_oe", bus.ps2c_oe, 0);
        check("rst_mid_ps2d_oe", bus.ps2d_oe, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.done, 0);
        void'(exp_q.pop_back());
        n = 0;
        while (dev_active && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (50) @(negedge clk);
        obs_q.delete();
        check("post_reset_idle_busy", bus.busy, 0);
        check("post_reset_idle_done", bus.done, 0);
        send(8'($urandom), 1'b0, 1'b1);
        wait_done("done_after_reset");
        do_ack();

        // Random transfers with random ACK/NACK.
        for (int t = 0; t < 3; t++) begin
            dev_nack = bit'($urandom_range(0, 1));
            send(8'($urandom), dev_nack, 1'b1);
            wait_done("done_random");
            do_ack();
            repeat (20) @(negedge clk);
        end
        dev_nack = 1'b0;

        repeat (50) @(negedge clk);
        check("expected_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
